// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter: requester owners,
// priority states, in-flight read tags and the fetch access width.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    PRIO_D  = 1'b0,
    PRIO_IF = 1'b1
  } state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam logic [2:0] W_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_tagpipe.sv
// Fixed-latency shift register of read tags; the tail entry says which
// requester owns the memory read data arriving this cycle.
module mem_arb_tagpipe
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_d_i,
  input  logic kill_if_i,
  output logic if_done_o,
  output logic d_done_o
);

  tag_t pipe_q [LATENCY];
  tag_t pipe_d [LATENCY];
  tag_t tail;

  // Shift one stage per cycle; a kill drops every fetch tag, including the one being pushed.
  always_comb begin
    pipe_d[0].owner = push_d_i ? OWN_D : OWN_IF;
    pipe_d[0].valid = push_i && !(kill_if_i && !push_d_i);
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i].owner = pipe_q[i-1].owner;
      pipe_d[i].valid = pipe_q[i-1].valid && !(kill_if_i && pipe_q[i-1].owner == OWN_IF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // The tail is also subject to a same-cycle flush so no stale fetch reaches IF.
  assign tail      = pipe_q[LATENCY-1];
  assign if_done_o = tail.valid && (tail.owner == OWN_IF) && !kill_if_i;
  assign d_done_o  = tail.valid && (tail.owner == OWN_D);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and data (MEM) stages with a
// starvation guard for fetch and tag-based routing of read responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, if_rdata_q, d_rdata_q;
  logic        if_win, d_win, if_done, d_done;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst) begin
      if_win = 1'b0;
      d_win  = 1'b0;
    end else if (state_q == PRIO_IF) begin
      if_win = if_req;
      d_win  = d_req && !if_req;
    end else begin
      d_win  = d_req;
      if_win = if_req && !d_req;
    end
  end

  assign if_gnt = if_win;
  assign d_gnt  = d_win;

  // Count consecutive denied fetch cycles; reaching the limit hands IF priority for one grant.
  always_comb begin
    starve_d = 4'd0;
    state_d  = state_q;
    if (if_req && !if_win) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
    case (state_q)
      PRIO_D:  state_d = (starve_d == LIMIT) ? PRIO_IF : PRIO_D;
      PRIO_IF: state_d = (if_win || !if_req) ? PRIO_D : PRIO_IF;
      default: state_d = PRIO_D;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_width = 3'b000;
    mem_addr  = addr_q;
    mem_wdata = 32'h0000_0000;
    if (rst) begin
      mem_addr = 32'h0000_0000;
    end else if (if_win) begin
      mem_width = W_WORD;
      mem_addr  = {2'b00, if_addr[31:2]};
    end else if (d_win) begin
      mem_we    = d_we;
      mem_width = d_width;
      mem_addr  = {2'b00, d_addr[31:2]};
      mem_wdata = d_wdata;
    end else begin
      mem_addr = addr_q;
    end
  end

  mem_arb_tagpipe #(
    .LATENCY (LATENCY)
  ) u_tagpipe (
    .clk       (clk),
    .rst       (rst),
    .push_i    (if_win || (d_win && !d_we)),
    .push_d_i  (d_win),
    .kill_if_i (if_flush),
    .if_done_o (if_done),
    .d_done_o  (d_done)
  );

  assign if_rvalid = !rst && if_done;
  assign d_rvalid  = !rst && d_done;
  assign if_rdata  = rst ? 32'h0000_0000 : (if_rvalid ? mem_rdata : if_rdata_q);
  assign d_rdata   = rst ? 32'h0000_0000 : (d_rvalid ? mem_rdata : d_rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRIO_D;
      starve_q   <= 4'd0;
      addr_q     <= 32'h0000_0000;
      if_rdata_q <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= mem_addr;
      if_rdata_q <= if_rdata;
      d_rdata_q  <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (LATENCY 1 and 3) share one stimulus stream and
// are checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int LIM = 4;

  typedef struct {
    int          cyc;
    bit          rst;
    bit          gi;
    bit          gd;
    bit          we;
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
  } iss_t;

  typedef struct {
    int          inst;
    int          own_d;
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst, if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_width;

  logic [1:0]        if_gnt_w, d_gnt_w, if_rvalid_w, d_rvalid_w, mem_we_w;
  logic [1:0][31:0]  if_rdata_w, d_rdata_w, mem_addr_w, mem_wdata_w, mem_rdata_w;
  logic [1:0][2:0]   mem_width_w;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   now   = 0;

  // reference model state
  int          streak;
  bit          forced;
  logic [31:0] hold_addr;
  bit          slot_v [2][8];
  logic [31:0] slot_d [2][8];
  logic [31:0] last_rd [2][2];

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(1), .STARVE_LIMIT(LIM)) u_l1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt_w[0]), .if_rvalid(if_rvalid_w[0]), .if_rdata(if_rdata_w[0]),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_w[0]), .d_rvalid(d_rvalid_w[0]), .d_rdata(d_rdata_w[0]),
    .mem_we(mem_we_w[0]), .mem_width(mem_width_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0])
  );

  mem_arbiter #(.LATENCY(3), .STARVE_LIMIT(LIM)) u_l3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt_w[1]), .if_rvalid(if_rvalid_w[1]), .if_rdata(if_rdata_w[1]),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_w[1]), .d_rvalid(d_rvalid_w[1]), .d_rdata(d_rdata_w[1]),
    .mem_we(mem_we_w[1]), .mem_width(mem_width_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // contents of the bench memory at a word address
  function automatic logic [31:0] dataf(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void chk(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp, input int cyc);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat%0d cycle %0d: got %h expected %h", name, lat(k), cyc, act, exp);
    end
  endfunction

  // One clock of stimulus plus the reference model's expectations for it.
  task automatic cycle(input bit r, input bit ir, input logic [31:0] ia, input bit fl,
                       input bit dr, input bit dwe, input logic [2:0] dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    iss_t e;
    rsp_t x;
    bit iw, dwn;
    logic [31:0] wa;
    @(posedge clk);
    #1;
    now++;
    rst = r; if_req = ir; if_addr = ia; if_flush = fl;
    d_req = dr; d_we = dwe; d_width = dw; d_addr = da; d_wdata = dwd;
    for (int k = 0; k < 2; k++) begin
      mem_rdata_w[k] = slot_v[k][now % 8] ? slot_d[k][now % 8] : $urandom;
      slot_v[k][now % 8] = 1'b0;
    end
    e.cyc = now; e.rst = r; e.gi = 1'b0; e.gd = 1'b0; e.we = 1'b0;
    e.w = 3'b000; e.wd = 32'h0; e.a = hold_addr;
    if (r) begin
      rsp_q.delete();
      streak = 0; forced = 1'b0; hold_addr = 32'h0; e.a = 32'h0;
    end else begin
      // fetch wins only when data is idle or it has been starved long enough
      iw  = ir && (!dr || forced);
      dwn = dr && !iw;
      wa  = hold_addr;
      if (iw) begin
        wa = ia >> 2; e.gi = 1'b1; e.w = 3'b010;
      end else if (dwn) begin
        wa = da >> 2; e.gd = 1'b1; e.we = dwe; e.w = dw; e.wd = dwd;
      end
      e.a = wa;
      hold_addr = wa;
      if (fl) begin
        for (int i = rsp_q.size() - 1; i >= 0; i--) begin
          if (rsp_q[i].own_d == 0) rsp_q.delete(i);
        end
      end
      if (iw || (dwn && !dwe)) begin
        for (int k = 0; k < 2; k++) begin
          slot_v[k][(now + lat(k)) % 8] = 1'b1;
          slot_d[k][(now + lat(k)) % 8] = dataf(wa);
          if (!(iw && fl)) begin
            x.inst = k; x.own_d = dwn ? 1 : 0; x.due = now + lat(k); x.data = dataf(wa);
            rsp_q.push_back(x);
          end
        end
      end
      if (ir && !iw) streak = (streak >= LIM) ? LIM : streak + 1;
      else streak = 0;
      forced = (streak == LIM);
    end
    iss_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // Monitor: pops the expected issue per cycle and matches responses against the scoreboard.
  always @(negedge clk) begin
    iss_t e;
    int idx;
    logic rv;
    logic [31:0] rd;
    if (iss_q.size() > 0) begin
      e = iss_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        chk("if_gnt", k, 32'(if_gnt_w[k]), 32'(e.gi), e.cyc);
        chk("d_gnt", k, 32'(d_gnt_w[k]), 32'(e.gd), e.cyc);
        chk("mem_we", k, 32'(mem_we_w[k]), 32'(e.we), e.cyc);
        chk("mem_addr", k, mem_addr_w[k], e.a, e.cyc);
        if (e.gi || e.gd) chk("mem_width", k, 32'(mem_width_w[k]), 32'(e.w), e.cyc);
        if (e.gd && e.we) chk("mem_wdata", k, mem_wdata_w[k], e.wd, e.cyc);
        if (e.rst) begin
          chk("rst_width", k, 32'(mem_width_w[k]), 32'h0, e.cyc);
          chk("rst_wdata", k, mem_wdata_w[k], 32'h0, e.cyc);
          chk("rst_rvalid", k, 32'({if_rvalid_w[k], d_rvalid_w[k]}), 32'h0, e.cyc);
          chk("rst_rdata", k, if_rdata_w[k] | d_rdata_w[k], 32'h0, e.cyc);
          last_rd[k][0] = 32'h0;
          last_rd[k][1] = 32'h0;
        end else begin
          for (int o = 0; o < 2; o++) begin
            rv  = (o == 1) ? d_rvalid_w[k] : if_rvalid_w[k];
            rd  = (o == 1) ? d_rdata_w[k] : if_rdata_w[k];
            idx = -1;
            for (int i = 0; i < rsp_q.size(); i++) begin
              if (idx < 0 && rsp_q[i].inst == k && rsp_q[i].own_d == o && rsp_q[i].due == e.cyc)
                idx = i;
            end
            chk((o == 1) ? "d_rvalid" : "if_rvalid", k, 32'(rv), 32'(idx >= 0), e.cyc);
            if (idx >= 0) begin
              chk((o == 1) ? "d_rdata" : "if_rdata", k, rd, rsp_q[idx].data, e.cyc);
              last_rd[k][o] = rsp_q[idx].data;
              rsp_q.delete(idx);
            end else begin
              chk((o == 1) ? "d_rdata_hold" : "if_rdata_hold", k, rd, last_rd[k][o], e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_width = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata_w = '0;
    streak = 0; forced = 1'b0; hold_addr = 32'h0;
    for (int k = 0; k < 2; k++) begin
      last_rd[k][0] = 32'h0;
      last_rd[k][1] = 32'h0;
      for (int s = 0; s < 8; s++) begin
        slot_v[k][s] = 1'b0;
        slot_d[k][s] = 32'h0;
      end
    end

    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);

    // back-to-back fetches
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    idle(4);

    // simultaneous fetch and load: data first, fetch next cycle
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    idle(4);

    // sustained data traffic with a waiting fetch
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 3'b010, 32'h400 + 32'(i * 4), 32'h0);
    idle(4);

    // fetch, then flush next cycle alongside a load
    cycle(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h108, 32'h0);
    idle(4);

    // byte store to an unaligned address
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h203, 32'hDEAD_BEEF);
    idle(4);

    // reset with two reads in flight
    cycle(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    idle(5);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    idle(6);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 0, 32'(rsp_q.size()), 32'h0, now);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port data/instruction memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline.
- Grants at most one access per cycle and tracks in-flight reads through a fixed-latency tag pipe, so each read response returns to its owner.
- Produces per-requester grant signals that the hazard logic uses as stall sources.
- A starvation guard guarantees fetch progress under sustained data traffic.

Parameters:
- LATENCY, 1, memory read latency in cycles from accepted request to rdata valid (1..4).
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced to highest priority (1..15).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- if_req  input  1  fetch request
- if_addr  input  32  fetch byte address (word aligned)
- if_flush  input  1  branch taken in EX; discard in-flight fetch responses
- if_gnt  output  1  fetch accepted this cycle
- if_rvalid  output  1  fetch data valid
- if_rdata  output  32  fetched instruction
- d_req  input  1  data request
- d_we  input  1  store when 1
- d_width  input  3  funct3 access width, passed through
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_gnt  output  1  data access accepted this cycle
- d_rvalid  output  1  load data valid
- d_rdata  output  32  load data
- mem_we  output  1  memory write enable
- mem_width  output  3  memory access width
- mem_addr  output  32  word address (byte address >> 2)
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid LATENCY cycles after the issue cycle

Behaviour:
- Reset: all outputs 0. The tag pipe is cleared, the starvation counter is 0, and the state is PRIO_D.
- Arbitration is combinational from the current state. At most one of if_gnt/d_gnt is high, and a grant occurs only when the matching req is high.
- States:
  - PRIO_D (default): d_req wins; IF is granted only when d_req=0.
  - PRIO_IF: if_req wins.
- Starvation counter:
  - Increments each cycle with if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Clears on if_gnt or if_req=0.
- Transitions:
  - PRIO_D -> PRIO_IF when the counter reaches STARVE_LIMIT.
  - PRIO_IF -> PRIO_D after one IF grant, or when if_req=0.
- Issue: when granted, drive mem_* from the winner in the same cycle.
  - IF issue: mem_we=0, mem_width=3'b010.
  - No grant: mem_we=0 and mem_addr holds its last value.
- Tag pipe: LATENCY-deep shift register of {valid, owner}. A tag is pushed only for reads (IF, or D with d_we=0); stores push valid=0.
- Response routing: at the pipe tail, when valid=1, mem_rdata goes to the owner's rdata and that owner's rvalid pulses for 1 cycle. rdata holds its last value when rvalid=0.
- if_flush: clears the valid bit of every in-flight IF-owned tag this cycle, so no stale if_rvalid appears afterwards. A fetch granted in the same cycle as if_flush is also discarded. D tags are unaffected.
- Simultaneous if_req and d_req with counter < limit: D granted, IF counter increments.
- Back-to-back reads are accepted every cycle; throughput is 1 access/cycle.
- Reset mid-operation drops all in-flight tags; no rvalid occurs in the cycle after rst is deasserted.

Decomposition:
- Shared package (mem_arb_pkg):
  - owner enum OWN_IF/OWN_D
  - state enum PRIO_D/PRIO_IF
  - tag struct {valid, owner}
  - width constant W_WORD=3'b010
- One sub-module: mem_arb_tagpipe (parameterised LATENCY shift register with per-owner kill input).

Test Plan:
- IF-only reads at 0x0, 0x4, 0x8 back-to-back, LATENCY=1 -> if_gnt=1 for three cycles; mem_addr=0,1,2; if_rvalid on cycles 2..4 with the matching words; d_rvalid never asserted.
- if_req and d_req (load at 0x100) in the same cycle -> d_gnt=1, if_gnt=0; IF granted the next cycle; d_rvalid precedes if_rvalid by 1 cycle.
- d_req held high for 10 cycles with if_req=1, STARVE_LIMIT=4 -> if_gnt asserted on cycle 5; D resumes on cycle 6; pattern repeats every 5 cycles.
- LATENCY=3: fetch issued, then if_flush 1 cycle later -> no if_rvalid for that fetch; a concurrent D load still returns d_rvalid with correct data.
- Store d_we=1, d_width=3'b000, d_addr=0x203 -> mem_we=1, mem_width=0, mem_addr=0x80; no d_rvalid produced.
- rst asserted with 2 reads in flight (LATENCY=3) -> all outputs 0; no rvalid in any cycle after rst deasserts until new grants occur.
